// File: rtl/fifo_mem_ctrl.sv
// Broadcast-write, multi-reader FIFO controller for the 8-bank sample memory; clears memory after reset/flush.
// Optional sticky overflow/underflow flags are built only when FIFO_MEM_CTRL_ERR_EN is defined.
module fifo_mem_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int NUM_OF_MEM = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_valid_i,
  input  logic signed [DATA_W-1:0]         wr_data_i,
  output logic                             wr_ready_o,
  input  logic [NUM_OF_MEM-1:0]            bank_en_i,
  input  logic [NUM_OF_MEM-1:0]            rd_req_i,
  output logic [NUM_OF_MEM-1:0]            rd_valid_o,
  input  logic                             flush_i,
  output logic signed [DATA_W-1:0]         mem_data_o,
  output logic [ADDR_W-1:0]                mem_w_addr_o,
  output logic [NUM_OF_MEM-1:0]            mem_w_en_o,
  output logic [ADDR_W*NUM_OF_MEM-1:0]     mem_r_addr_o,
  output logic [NUM_OF_MEM-1:0]            mem_r_en_o,
  output logic [NUM_OF_MEM-1:0]            empty_o,
  output logic                             full_o,
  output logic [(ADDR_W+1)*NUM_OF_MEM-1:0] level_o,
  output logic                             init_done_o,
  output logic                             ovf_o,
  output logic [NUM_OF_MEM-1:0]            unf_o,
  input  logic                             err_clr_i
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_W:0]   LVL_FULL  = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH-1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q [NUM_OF_MEM];
  logic [ADDR_W-1:0]     rd_ptr_d [NUM_OF_MEM];
  logic [ADDR_W:0]       level_q [NUM_OF_MEM];
  logic [ADDR_W:0]       level_d [NUM_OF_MEM];
  logic [NUM_OF_MEM-1:0] rd_valid_q, rd_valid_d;

  logic                  run;
  logic                  full;
  logic                  wr_acc;
  logic [NUM_OF_MEM-1:0] empty;
  logic [NUM_OF_MEM-1:0] rd_acc;

  assign run = (state_q == ST_RUN);

  // Status is derived only from registered levels, so ready/full never depend on this cycle's traffic.
  always_comb begin
    full = 1'b0;
    for (int n = 0; n < NUM_OF_MEM; n++) begin
      empty[n] = ~bank_en_i[n] | (level_q[n] == '0);
      full     = full | (bank_en_i[n] & (level_q[n] == LVL_FULL));
      level_o[(ADDR_W+1)*n +: (ADDR_W+1)] = level_q[n];
      mem_r_addr_o[ADDR_W*n +: ADDR_W]    = rd_ptr_q[n];
    end
  end

  assign wr_acc = run & ~flush_i & wr_valid_i & ~full;
  assign rd_acc = (run & ~flush_i) ? (rd_req_i & ~empty) : '0;

  assign wr_ready_o  = run & ~full;
  assign full_o      = full;
  assign empty_o     = empty;
  assign init_done_o = run;
  assign rd_valid_o  = rd_valid_q;
  assign mem_r_en_o  = rd_acc;

  // While clearing, every bank is written with zero at the clear address; held off during reset.
  always_comb begin
    mem_w_en_o   = '0;
    mem_w_addr_o = wr_ptr_q;
    mem_data_o   = wr_data_i;
    if (!run) begin
      mem_w_en_o   = reset ? '0 : '1;
      mem_w_addr_o = clr_cnt_q;
      mem_data_o   = '0;
    end else if (wr_acc) begin
      mem_w_en_o = bank_en_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_valid_d = rd_acc;
    case (state_q)
      ST_INIT: begin
        clr_cnt_d = clr_cnt_q + PTR_ONE;
        wr_ptr_d  = '0;
        for (int n = 0; n < NUM_OF_MEM; n++) begin
          rd_ptr_d[n] = '0;
          level_d[n]  = '0;
        end
        if (clr_cnt_q == ADDR_LAST) state_d = ST_RUN;
      end
      default: begin
        if (flush_i) begin
          state_d   = ST_INIT;
          clr_cnt_d = '0;
        end
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        // A disabled reader tracks the write pointer so re-enabling starts it empty.
        for (int n = 0; n < NUM_OF_MEM; n++) begin
          if (!bank_en_i[n]) begin
            rd_ptr_d[n] = wr_ptr_d;
            level_d[n]  = '0;
          end else begin
            if (rd_acc[n]) rd_ptr_d[n] = rd_ptr_q[n] + PTR_ONE;
            case ({wr_acc, rd_acc[n]})
              2'b10:   level_d[n] = level_q[n] + LVL_ONE;
              2'b01:   level_d[n] = level_q[n] - LVL_ONE;
              default: level_d[n] = level_q[n];
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      clr_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_valid_q <= '0;
      for (int n = 0; n < NUM_OF_MEM; n++) begin
        rd_ptr_q[n] <= '0;
        level_q[n]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

`ifdef FIFO_MEM_CTRL_ERR_EN
  logic                  ovf_q, ovf_d;
  logic [NUM_OF_MEM-1:0] unf_q, unf_d;

  // Set has priority over err_clr_i; flush clears everything.
  always_comb begin
    ovf_d = ovf_q & ~err_clr_i;
    unf_d = err_clr_i ? '0 : unf_q;
    if (run) begin
      if (flush_i) begin
        ovf_d = 1'b0;
        unf_d = '0;
      end else begin
        if (wr_valid_i & ~wr_ready_o) ovf_d = 1'b1;
        unf_d = unf_d | (rd_req_i & bank_en_i & empty);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign unf_o = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign ovf_o = 1'b0;
  assign unf_o = '0;
`endif

endmodule

// File: doc/fifo_mem_ctrl.md
Name: fifo_mem_ctrl

Overview:
- Controller that sequences the 8-bank dual-port sample memory (8 x 256x16) as one broadcast-write, multi-reader FIFO.
- Each incoming ECG sample is written to every enabled bank at one shared write pointer. Each bank is then drained independently by its own feature-extraction consumer through a private read pointer.
- Clears all memory contents after reset and on flush, so filter delay lines start from zero.
- Sits between the sample front-end and the bank memory; drives the memory's data, w_addr, r_addr, w_en and r_en inputs directly.

Parameters:
- DATA_W, 16, sample width.
- ADDR_W, 8, address width per bank.
- NUM_OF_MEM, 8, number of banks/readers.
- MEM_DEPTH, 256, entries per bank; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_valid_i  in  1  sample valid.
- wr_data_i  in  DATA_W  signed sample.
- wr_ready_o  out  1  sample accepted when high together with wr_valid_i.
- bank_en_i  in  NUM_OF_MEM  bank enable mask; quasi-static.
- rd_req_i  in  NUM_OF_MEM  per-bank read request.
- rd_valid_o  out  NUM_OF_MEM  memory q of bank n is valid this cycle.
- flush_i  in  1  synchronous flush and re-clear request.
- mem_data_o  out  DATA_W  to memory data.
- mem_w_addr_o  out  ADDR_W  to memory w_addr.
- mem_w_en_o  out  NUM_OF_MEM  to memory w_en.
- mem_r_addr_o  out  ADDR_W*NUM_OF_MEM  to memory r_addr; bank n occupies slice [ADDR_W*(n+1)-1 : ADDR_W*n].
- mem_r_en_o  out  NUM_OF_MEM  to memory r_en.
- empty_o  out  NUM_OF_MEM  per-bank empty.
- full_o  out  1  any enabled bank holds MEM_DEPTH entries.
- level_o  out  (ADDR_W+1)*NUM_OF_MEM  per-bank occupancy count.
- init_done_o  out  1  clear complete; FIFO is operational.
- ovf_o  out  1  sticky overflow flag (see Optional Feature).
- unf_o  out  NUM_OF_MEM  sticky per-bank underflow flags (see Optional Feature).
- err_clr_i  in  1  clears ovf_o and unf_o.

Behaviour:

Reset (async, while reset=1):
- State is INIT; clear counter, wr_ptr, all rd_ptr and all levels are 0.
- wr_ready_o, rd_valid_o, mem_w_en_o, mem_r_en_o, init_done_o, full_o, ovf_o and unf_o are 0.
- empty_o is all ones.

FSM, state INIT:
- mem_w_en_o is all ones; mem_w_addr_o equals the clear counter; mem_data_o is 0.
- Clear counter increments every cycle, covering addresses 0..MEM_DEPTH-1 (MEM_DEPTH cycles in total).
- wr_ready_o is 0, all reads are ignored, flush_i is ignored.
- After address MEM_DEPTH-1 is written, the FSM moves to RUN with wr_ptr, all rd_ptr and all levels at 0.

FSM, state RUN:
- init_done_o is 1.
- flush_i=1: move to INIT; no read or write is accepted that cycle; rd_valid_o is 0 the following cycle.

Write path (RUN):
- wr_ready_o = !full_o, combinational from registered levels.
- On accept: mem_w_en_o = bank_en_i, mem_w_addr_o = wr_ptr, mem_data_o = wr_data_i (same cycle, combinational); wr_ptr increments modulo MEM_DEPTH.

Read path (RUN):
- rd_req_i[n] is accepted when bank_en_i[n]=1 and empty_o[n]=0.
- On accept: mem_r_en_o[n]=1 and slice n = rd_ptr[n] in the same cycle; rd_ptr[n] increments modulo MEM_DEPTH.
- rd_valid_o[n]=1 exactly 1 cycle later (registered memory output).
- A request on an empty or disabled bank is ignored: no r_en, no pointer change.

Level accounting, per enabled bank n:
- Level +1 on write only, -1 on read only, unchanged on simultaneous read and write.
- A read and write in the same cycle on a non-empty bank are both accepted.
- empty_o[n] = (level==0).
- full_o = OR over enabled banks of (level==MEM_DEPTH).

Disabled bank (bank_en_i[n]=0):
- Level is held 0 and empty_o[n]=1.
- rd_ptr[n] is loaded with the next value of wr_ptr every cycle.
- Re-enabling therefore starts the bank empty at the current write position.

Wrap-around:
- All pointers wrap from MEM_DEPTH-1 to 0.
- A level of MEM_DEPTH with rd_ptr==wr_ptr means full, never empty.

Optional Feature:
- Macro: FIFO_MEM_CTRL_ERR_EN.

With FIFO_MEM_CTRL_ERR_EN defined:
- ovf_o is set when wr_valid_i=1 and wr_ready_o=0 in RUN.
- unf_o[n] is set when rd_req_i[n]=1 on an enabled, empty bank in RUN.
- Both flags are sticky; err_clr_i clears them the next cycle. If set and clear coincide, set wins.
- flush_i also clears both flags.

Without FIFO_MEM_CTRL_ERR_EN:
- ovf_o and unf_o are tied 0; err_clr_i is unused.
- No flag registers are synthesised.

Test Plan:
- Release reset -> mem_w_en_o=8'hFF for exactly 256 cycles with addresses 0..255 and data 0; init_done_o rises on cycle 256; wr_ready_o=1.
- bank_en_i=8'hFF, write 3 samples (100,-5,7), then rd_req_i[2] for 3 cycles -> r_addr slice 2 = 0,1,2; rd_valid_o[2] one cycle after each read; level_o bank2 ends at 0 and every other bank at 3.
- Write 256 samples with no reads -> full_o=1, wr_ready_o=0. One read on bank 0 does not clear full_o (other banks still full). Disable banks 1-7 -> full_o drops, wr_ready_o=1.
- At level 10 on bank 0, simultaneous write and read for 300 cycles -> level stays 10, pointers wrap past 255 to 0, data read back in write order.
- Assert flush_i in RUN with level 50 -> next cycle INIT, 256 clear writes, then all levels 0 and empty_o=8'hFF.
- With FIFO_MEM_CTRL_ERR_EN defined: write when full sets ovf_o; read bank 4 when empty sets unf_o[4]; err_clr_i clears both. Without the macro, the same stimulus leaves both flags at 0.
